// File: rtl/vga_timing_pkg.sv
// Shared 640x480 timing defaults, counter widths and monitor state encoding.
package vga_timing_pkg;

    // Default 640x480@60 timing in pixels / lines
    localparam int unsigned VGA_H_ACTIVE    = 640;
    localparam int unsigned VGA_H_FRONT     = 16;
    localparam int unsigned VGA_H_SYNC      = 96;
    localparam int unsigned VGA_H_BACK      = 48;
    localparam int unsigned VGA_V_ACTIVE    = 480;
    localparam int unsigned VGA_V_FRONT     = 10;
    localparam int unsigned VGA_V_SYNC      = 2;
    localparam int unsigned VGA_V_BACK      = 33;
    localparam int unsigned VGA_LOCK_FRAMES = 2;

    // Derived totals
    localparam int unsigned VGA_LINE  = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int unsigned VGA_FRAME = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Counter and output widths
    localparam int unsigned HCNT_W = 11;
    localparam int unsigned VCNT_W = 11;
    localparam int unsigned X_W    = 10;
    localparam int unsigned Y_W    = 9;
    localparam int unsigned ERR_W  = 8;
    localparam int unsigned GOOD_W = 4;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } mon_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Enable-qualified sync sampler with falling/rising edge detect.
// Edges compare the live input against the last enabled sample, so they
// are valid in the same clk as the enable.
module vga_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_sync_n,
    output logic o_fall_c,
    output logic o_rise_c
);

    logic r_prev;

    // Hold the last sampled level; idle-high after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= 1'b1;
        end else if (i_en) begin
            r_prev <= i_sync_n;
        end
    end

    assign o_fall_c = i_en &  r_prev & ~i_sync_n;
    assign o_rise_c = i_en & ~r_prev &  i_sync_n;

endmodule

// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing monitor: measures hsync/vsync timing, locks to a
// conforming stream and recovers the active-pixel position.
module vga_timing_monitor
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
    parameter int unsigned H_FRONT     = VGA_H_FRONT,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_BACK      = VGA_H_BACK,
    parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
    parameter int unsigned V_FRONT     = VGA_V_FRONT,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_BACK      = VGA_V_BACK,
    parameter int unsigned LOCK_FRAMES = VGA_LOCK_FRAMES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pixel_strobe,
    input  logic              hsync_n,
    input  logic              vsync_n,
    output logic              locked,
    output logic              pix_active,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic              frame_start,
    output logic              line_err,
    output logic              frame_err,
    output logic [ERR_W-1:0]  err_count,
    output logic [HCNT_W-1:0] meas_line,
    output logic [VCNT_W-1:0] meas_frame
);

    localparam int unsigned LINE      = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned FRAME     = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_TIMEOUT = 2 * LINE;
    localparam int unsigned H_START   = H_SYNC + H_BACK;
    localparam int unsigned V_START   = V_SYNC + V_BACK;

    localparam logic [HCNT_W-1:0] C_LINE      = HCNT_W'(LINE);
    localparam logic [HCNT_W-1:0] C_HSYNC     = HCNT_W'(H_SYNC);
    localparam logic [HCNT_W-1:0] C_HTO       = HCNT_W'(H_TIMEOUT);
    localparam logic [HCNT_W-1:0] C_HTO_LAST  = HCNT_W'(H_TIMEOUT - 1);
    localparam logic [HCNT_W-1:0] C_H_START   = HCNT_W'(H_START);
    localparam logic [HCNT_W-1:0] C_H_END     = HCNT_W'(H_START + H_ACTIVE);
    localparam logic [VCNT_W-1:0] C_FRAME     = VCNT_W'(FRAME);
    localparam logic [VCNT_W-1:0] C_VSYNC     = VCNT_W'(V_SYNC);
    localparam logic [VCNT_W-1:0] C_V_START   = VCNT_W'(V_START);
    localparam logic [VCNT_W-1:0] C_V_END     = VCNT_W'(V_START + V_ACTIVE);
    localparam logic [GOOD_W-1:0] C_GOOD_LAST = GOOD_W'(LOCK_FRAMES - 1);

    mon_state_t        r_state;
    logic [HCNT_W-1:0] r_hcount;
    logic [VCNT_W-1:0] r_vcount;
    logic [VCNT_W-1:0] r_vs_width;
    logic [GOOD_W-1:0] r_good;
    logic              r_locked;
    logic              r_pix_active;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic              r_frame_start;
    logic              r_line_err;
    logic              r_frame_err;
    logic [ERR_W-1:0]  r_err_count;
    logic [HCNT_W-1:0] r_meas_line;
    logic [VCNT_W-1:0] r_meas_frame;

    logic              w_hf;
    logic              w_hr;
    logic              w_vf;
    logic              w_vr;
    logic [HCNT_W-1:0] w_hcount_inc;
    logic [VCNT_W-1:0] w_vcount_inc;
    logic [HCNT_W-1:0] w_hcount_nxt;
    logic [VCNT_W-1:0] w_vcount_nxt;
    logic              w_timeout;
    logic              w_line_fail;
    logic              w_frame_fail;
    logic              w_fail;
    logic              w_lock_enter;
    logic              w_locked_nxt;
    logic              w_pix_active;

    // hsync edges on every pixel strobe
    vga_sync_edge u_hsync_edge (
        .clk      (clk),
        .reset    (reset),
        .i_en     (pixel_strobe),
        .i_sync_n (hsync_n),
        .o_fall_c (w_hf),
        .o_rise_c (w_hr)
    );

    // vsync edges sampled only at line starts
    vga_sync_edge u_vsync_edge (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_hf),
        .i_sync_n (vsync_n),
        .o_fall_c (w_vf),
        .o_rise_c (w_vr)
    );

    assign w_hcount_inc = r_hcount + HCNT_W'(1);
    assign w_vcount_inc = r_vcount + VCNT_W'(1);

    // hcount stalls at the timeout value so a dead hsync reports only once
    assign w_hcount_nxt = w_hf ? '0 :
                          ((r_hcount == C_HTO) || (r_hcount == '1)) ? r_hcount : w_hcount_inc;
    assign w_vcount_nxt = w_vf ? '0 :
                          (w_hf && (r_vcount != '1)) ? w_vcount_inc : r_vcount;

    // vsync width is the number of lines spent low, counted at the rising edge
    assign w_timeout    = pixel_strobe & ~w_hf & (r_hcount == C_HTO_LAST);
    assign w_line_fail  = (w_hf & (w_hcount_inc != C_LINE))
                        | (w_hr & (w_hcount_inc != C_HSYNC))
                        | w_timeout;
    assign w_frame_fail = w_vf & ((w_vcount_inc != C_FRAME) | (r_vs_width != C_VSYNC));

    assign w_fail       = (r_state != ST_SEARCH) & (w_line_fail | w_frame_fail);
    assign w_lock_enter = (r_state == ST_MEASURE) & w_vf & ~w_fail & (r_good >= C_GOOD_LAST);
    assign w_locked_nxt = ((r_state == ST_LOCKED) & ~w_fail) | w_lock_enter;

    assign w_pix_active = w_locked_nxt
                        & (w_hcount_nxt >= C_H_START) & (w_hcount_nxt < C_H_END)
                        & (w_vcount_nxt >= C_V_START) & (w_vcount_nxt < C_V_END);

    // Line/frame counters and the last measured lengths/widths
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hcount     <= '0;
            r_vcount     <= '0;
            r_vs_width   <= '0;
            r_meas_line  <= '0;
            r_meas_frame <= '0;
        end else if (pixel_strobe) begin
            r_hcount <= w_hcount_nxt;
            r_vcount <= w_vcount_nxt;
            if (w_hf) begin
                r_meas_line <= w_hcount_inc;
            end
            if (w_vf) begin
                r_meas_frame <= w_vcount_inc;
            end
            if (w_vr) begin
                r_vs_width <= w_vcount_inc;
            end
        end
    end

    // Lock FSM with registered status, pulses and error counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_SEARCH;
            r_good        <= '0;
            r_locked      <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_err    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_frame_start <= 1'b0;
            r_line_err    <= 1'b0;
            r_frame_err   <= 1'b0;
            if (pixel_strobe) begin
                r_locked <= w_locked_nxt;
                case (r_state)
                    ST_SEARCH: begin
                        if (w_vf) begin
                            r_state <= ST_MEASURE;
                            r_good  <= '0;
                        end
                    end
                    ST_MEASURE: begin
                        if (w_fail) begin
                            r_state     <= ST_SEARCH;
                            r_line_err  <= w_line_fail;
                            r_frame_err <= w_frame_fail;
                        end else if (w_vf) begin
                            r_good <= r_good + GOOD_W'(1);
                            if (w_lock_enter) begin
                                r_state       <= ST_LOCKED;
                                r_frame_start <= 1'b1;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (w_fail) begin
                            r_state     <= ST_SEARCH;
                            r_line_err  <= w_line_fail;
                            r_frame_err <= w_frame_fail;
                            if (r_err_count != '1) begin
                                r_err_count <= r_err_count + ERR_W'(1);
                            end
                        end else if (w_vf) begin
                            r_frame_start <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_SEARCH;
                    end
                endcase
            end
        end
    end

    // Recovered pixel position for the pixel sampled on this strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_active <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
        end else if (pixel_strobe) begin
            r_pix_active <= w_pix_active;
            r_x          <= w_pix_active ? X_W'(w_hcount_nxt - C_H_START) : '0;
            r_y          <= w_pix_active ? Y_W'(w_vcount_nxt - C_V_START) : '0;
        end
    end

    assign locked      = r_locked;
    assign pix_active  = r_pix_active;
    assign x           = r_x;
    assign y           = r_y;
    assign frame_start = r_frame_start;
    assign line_err    = r_line_err;
    assign frame_err   = r_frame_err;
    assign err_count   = r_err_count;
    assign meas_line   = r_meas_line;
    assign meas_frame  = r_meas_frame;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor using a scaled 16x8 timing so whole frames
// fit in a short run; a line-level model predicts every output per clk.
module tb_vga_timing_monitor;

    localparam int HA = 16, HFP = 4, HSW = 6, HBP = 4;
    localparam int VA = 8,  VFP = 2, VSW = 2, VBP = 3;
    localparam int LOCKN = 2;
    localparam int LINE  = HA + HFP + HSW + HBP;   // 30
    localparam int FRAME = VA + VFP + VSW + VBP;   // 15

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pixel_strobe = 1'b0;
    logic       hsync_n = 1'b1;
    logic       vsync_n = 1'b1;
    logic       locked, pix_active, frame_start, line_err, frame_err;
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] err_count;
    logic [10:0] meas_line, meas_frame;

    vga_timing_monitor #(
        .H_ACTIVE(HA), .H_FRONT(HFP), .H_SYNC(HSW), .H_BACK(HBP),
        .V_ACTIVE(VA), .V_FRONT(VFP), .V_SYNC(VSW), .V_BACK(VBP),
        .LOCK_FRAMES(LOCKN)
    ) dut (
        .clk(clk), .reset(reset), .pixel_strobe(pixel_strobe),
        .hsync_n(hsync_n), .vsync_n(vsync_n),
        .locked(locked), .pix_active(pix_active), .x(x), .y(y),
        .frame_start(frame_start), .line_err(line_err), .frame_err(frame_err),
        .err_count(err_count), .meas_line(meas_line), .meas_frame(meas_frame)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;
    bit probe   = 1'b0;
    int fs_cnt  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Model view: position within line / line within frame, counted from
    // the last observed sync falling edges; mode 0=search 1=measure 2=locked.
    int m_hs_last = 1, m_vs_last = 1;
    int m_pos = 0, m_lnum = 0, m_vs_low = 0;
    int m_mode = 0, m_good = 0;
    int e_locked = 0, e_act = 0, e_x = 0, e_y = 0;
    int e_fs = 0, e_le = 0, e_fe = 0, e_err = 0, e_ml = 0, e_mf = 0;

    task automatic model_pixel(input int hs, input int vs);
        bit line_start, h_end_pulse, v_start, v_end_pulse, bad_line, bad_frame;
        int hx, vy;
        line_start  = (m_hs_last == 1) && (hs == 0);
        h_end_pulse = (m_hs_last == 0) && (hs == 1);
        m_hs_last   = hs;
        v_start = 0; v_end_pulse = 0; bad_line = 0; bad_frame = 0;
        if (line_start) begin
            v_start     = (m_vs_last == 1) && (vs == 0);
            v_end_pulse = (m_vs_last == 0) && (vs == 1);
            m_vs_last   = vs;
            e_ml = m_pos + 1;
            bad_line = (e_ml != LINE);
            m_pos = 0;
            if (v_end_pulse) m_vs_low = m_lnum + 1;
            if (v_start) begin
                e_mf = m_lnum + 1;
                bad_frame = (e_mf != FRAME) || (m_vs_low != VSW);
                m_lnum = 0;
            end else if (m_lnum < 2047) begin
                m_lnum++;
            end
        end else begin
            if (h_end_pulse && (m_pos + 1 != HSW)) bad_line = 1;
            if (m_pos == 2 * LINE - 1) bad_line = 1;
            if (m_pos < 2 * LINE) m_pos++;
        end
        if (m_mode == 0) begin
            if (v_start) begin m_mode = 1; m_good = 0; end
        end else if (bad_line || bad_frame) begin
            e_le = bad_line; e_fe = bad_frame;
            if (m_mode == 2 && e_err < 255) e_err++;
            m_mode = 0;
        end else if (v_start) begin
            if (m_mode == 2) e_fs = 1;
            else begin
                m_good++;
                if (m_good >= LOCKN) begin m_mode = 2; e_fs = 1; end
            end
        end
        e_locked = (m_mode == 2);
        hx = m_pos - (HSW + HBP);
        vy = m_lnum - (VSW + VBP);
        e_act = e_locked && hx >= 0 && hx < HA && vy >= 0 && vy < VA;
        e_x = e_act ? hx : 0;
        e_y = e_act ? vy : 0;
    endtask

    // Model advances on the same edge the DUT samples
    always @(posedge clk) begin
        if (reset) begin
            m_hs_last = 1; m_vs_last = 1; m_pos = 0; m_lnum = 0; m_vs_low = 0;
            m_mode = 0; m_good = 0;
            e_locked = 0; e_act = 0; e_x = 0; e_y = 0;
            e_fs = 0; e_le = 0; e_fe = 0; e_err = 0; e_ml = 0; e_mf = 0;
        end else begin
            e_fs = 0; e_le = 0; e_fe = 0;
            if (pixel_strobe) model_pixel(int'(hsync_n), int'(vsync_n));
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("locked",      int'(locked),      e_locked);
            check("pix_active",  int'(pix_active),  e_act);
            check("x",           int'(x),           e_x);
            check("y",           int'(y),           e_y);
            check("frame_start", int'(frame_start), e_fs);
            check("line_err",    int'(line_err),    e_le);
            check("frame_err",   int'(frame_err),   e_fe);
            check("err_count",   int'(err_count),   e_err);
            check("meas_line",   int'(meas_line),   e_ml);
            check("meas_frame",  int'(meas_frame),  e_mf);
        end
        if (frame_start) fs_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic px(input logic hs, input logic vs);
        @(negedge clk);
        pixel_strobe = 1'b1; hsync_n = hs; vsync_n = vs;
        @(negedge clk);
        pixel_strobe = 1'b0;
    endtask

    task automatic line(input int idx, input int len, input int hsw, input int vsw);
        for (int p = 0; p < len; p++) begin
            px((p < hsw) ? 1'b0 : 1'b1, (idx < vsw) ? 1'b0 : 1'b1);
            if (probe && idx == 5 && p == 10) begin
                check("lit_x_first",   int'(x), 0);
                check("lit_y_first",   int'(y), 0);
                check("lit_act_first", int'(pix_active), 1);
            end
            if (probe && idx == 12 && p == 25) begin
                check("lit_x_last",   int'(x), 15);
                check("lit_y_last",   int'(y), 7);
                check("lit_act_last", int'(pix_active), 1);
            end
            if (probe && idx == 12 && p == 26) begin
                check("lit_act_after", int'(pix_active), 0);
                check("lit_x_after",   int'(x), 0);
            end
        end
    endtask

    task automatic frame(input int vsw);
        for (int l = 0; l < FRAME; l++) line(l, LINE, HSW, vsw);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_act"},    int'(pix_active), 0);
        check({tag, "_xy"},     int'(x) + int'(y), 0);
        check({tag, "_pulses"}, int'(frame_start) + int'(line_err) + int'(frame_err), 0);
        check({tag, "_err"},    int'(err_count), 0);
        check({tag, "_meas"},   int'(meas_line) + int'(meas_frame), 0);
    endtask

    initial begin
        // Reset, with a strobe and hsync low that reset must override
        @(negedge clk);
        pixel_strobe = 1'b1; hsync_n = 1'b0;
        @(negedge clk);
        pixel_strobe = 1'b0; hsync_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        check_all_zero("reset");
        reset = 1'b0;

        // Idle strobes with both syncs high
        repeat (20) px(1'b1, 1'b1);
        check("idle_err", int'(err_count), 0);
        check("idle_locked", int'(locked), 0);

        // Ideal stream: lock at the third vsync fall
        frame(VSW);
        frame(VSW);
        check("prelock_locked", int'(locked), 0);
        frame(VSW);
        check("lock_locked", int'(locked), 1);
        check("lock_meas_line", int'(meas_line), 30);
        check("lock_meas_frame", int'(meas_frame), 15);
        check("lock_err", int'(err_count), 0);
        probe = 1'b1;
        frame(VSW);
        probe = 1'b0;
        check("fs_count", fs_cnt, 2);

        // One short line while locked
        for (int l = 0; l < 5; l++) line(l, LINE, HSW, VSW);
        line(5, LINE - 1, HSW, VSW);
        line(6, LINE, HSW, VSW);
        check("short_err", int'(err_count), 1);
        check("short_locked", int'(locked), 0);
        check("short_meas", int'(meas_line), 29);
        for (int l = 7; l < FRAME; l++) line(l, LINE, HSW, VSW);
        frame(VSW);
        frame(VSW);
        check("relock_pre", int'(locked), 0);
        frame(VSW);
        check("relock", int'(locked), 1);

        // vsync three lines wide while locked
        frame(3);
        line(0, LINE, HSW, VSW);
        check("vsw_err", int'(err_count), 2);
        check("vsw_locked", int'(locked), 0);
        for (int l = 1; l < FRAME; l++) line(l, LINE, HSW, VSW);

        // Narrow hsync while measuring: no count
        for (int l = 0; l < 3; l++) line(l, LINE, HSW, VSW);
        line(3, LINE, HSW - 1, VSW);
        check("hsw_err", int'(err_count), 2);
        check("hsw_locked", int'(locked), 0);
        for (int l = 4; l < FRAME; l++) line(l, LINE, HSW, VSW);

        // Relock, then hsync stuck high for a full timeout
        frame(VSW);
        frame(VSW);
        for (int l = 0; l < 4; l++) line(l, LINE, HSW, VSW);
        check("to_pre_locked", int'(locked), 1);
        line(4, LINE, HSW, VSW);
        repeat (2 * LINE) px(1'b1, 1'b1);
        check("to_err", int'(err_count), 3);
        check("to_locked", int'(locked), 0);
        for (int l = 5; l < FRAME; l++) line(l, LINE, HSW, VSW);

        // Mid-frame reset, overriding a strobe
        for (int l = 0; l < 7; l++) line(l, LINE, HSW, VSW);
        @(negedge clk);
        reset = 1'b1; pixel_strobe = 1'b1; hsync_n = 1'b0;
        @(negedge clk);
        pixel_strobe = 1'b0; hsync_n = 1'b1;
        check_all_zero("midrst");
        @(negedge clk);
        reset = 1'b0;
        for (int l = 7; l < FRAME; l++) line(l, LINE, HSW, VSW);
        frame(VSW);
        frame(VSW);
        check("rst_relock_pre", int'(locked), 0);
        frame(VSW);
        check("rst_relock", int'(locked), 1);
        check("rst_err", int'(err_count), 0);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
